// File: rtl/strip_placement_scheduler_if.sv
// Request/response handshake bundle for strip_placement_scheduler.
// master drives requests and accepts responses; slave is the scheduler.
interface strip_placement_scheduler_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_width;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_strip_id;
  logic [7:0] resp_x;
  logic       resp_fail;

  modport master (
    output req_valid,
    output req_width,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_strip_id,
    input  resp_x,
    input  resp_fail
  );

  modport slave (
    input  req_valid,
    input  req_width,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_strip_id,
    output resp_x,
    output resp_fail
  );
endinterface

// File: rtl/strip_placement_scheduler.sv
// Sequential least-occupied-fit strip placer; owns per-strip occupancy.
// Ports: clk, rst_n, bus (slave handshake), clear, occ_rd_id/occ_rd_width;
// PLACEMENT_STATS_EN adds placed_count/fail_count saturating counters.
module strip_placement_scheduler #(
  parameter int NUM_STRIPS  = 13,
  parameter int STRIP_WIDTH = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  strip_placement_scheduler_if.slave bus,
  input  logic       clear,
  input  logic [3:0] occ_rd_id,
  output logic [7:0] occ_rd_width
`ifdef PLACEMENT_STATS_EN
  ,
  output logic [15:0] placed_count,
  output logic [15:0] fail_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    COMMIT,
    RESP
  } state_t;

  localparam logic [8:0] CAP  = 9'(STRIP_WIDTH);
  localparam logic [3:0] LAST = 4'(NUM_STRIPS - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] occ [NUM_STRIPS];
  logic [7:0] width_q;
  logic [7:0] occ_k;
  logic [7:0] best_occ;
  logic [7:0] rsp_x;
  logic [3:0] idx;
  logic [3:0] best_id;
  logic [3:0] rsp_id;
  logic       best_found;
  logic       rsp_fail;
  logic       accept;
  logic       clr;
  logic       bad_width;
  logic       fit;
  logic       better;

  assign accept = (state == IDLE) && !clear && bus.req_valid;
  assign clr    = (state == IDLE) && clear;

  assign bad_width = (width_q == 8'd0) ||
                     ({1'b0, width_q} > CAP);

  always_comb begin
    occ_k = 8'd0;
    for (int i = 0; i < NUM_STRIPS; i++)
      if (idx == 4'(i))
        occ_k = occ[i];
  end

  always_comb begin
    occ_rd_width = 8'd0;
    for (int i = 0; i < NUM_STRIPS; i++)
      if (occ_rd_id == 4'(i))
        occ_rd_width = occ[i];
  end

  // 9-bit sum so a near-full strip cannot wrap into a false fit
  assign fit = ({1'b0, occ_k} + {1'b0, width_q}) <= CAP;
  // strict less-than keeps the lowest ID on ties
  assign better = fit && (!best_found || (occ_k < best_occ));

  assign bus.req_ready     = (state == IDLE) && !clear;
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_strip_id = rsp_id;
  assign bus.resp_x        = rsp_x;
  assign bus.resp_fail     = rsp_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = CHECK;
      CHECK:
        state_nx = bad_width ? COMMIT : SCAN;
      SCAN:
        if (idx == LAST)
          state_nx = COMMIT;
      COMMIT:
        state_nx = RESP;
      RESP:
        if (bus.resp_ready)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q    <= 8'd0;
      idx        <= 4'd0;
      best_found <= 1'b0;
      best_id    <= 4'd0;
      best_occ   <= 8'd0;
      rsp_id     <= 4'd0;
      rsp_x      <= 8'd0;
      rsp_fail   <= 1'b0;
    end else begin
      if (accept)
        width_q <= bus.req_width;
      if (state == CHECK) begin
        idx        <= 4'd0;
        best_found <= 1'b0;
        best_id    <= 4'd0;
        best_occ   <= 8'd0;
      end
      if (state == SCAN) begin
        idx <= idx + 4'd1;
        if (better) begin
          best_found <= 1'b1;
          best_id    <= idx;
          best_occ   <= occ_k;
        end
      end
      if (state == COMMIT) begin
        rsp_id   <= best_found ? best_id : 4'd0;
        rsp_x    <= best_found ? best_occ : 8'd0;
        rsp_fail <= !best_found;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STRIPS; i++)
        occ[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_STRIPS; i++) begin
        if (clr)
          occ[i] <= 8'd0;
        else if ((state == COMMIT) && best_found &&
                 (best_id == 4'(i)))
          occ[i] <= occ[i] + width_q;
      end
    end
  end

`ifdef PLACEMENT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      placed_count <= 16'd0;
      fail_count   <= 16'd0;
    end else if (clr) begin
      placed_count <= 16'd0;
      fail_count   <= 16'd0;
    end else if (state == COMMIT) begin
      if (best_found && (placed_count != 16'hFFFF))
        placed_count <= placed_count + 16'd1;
      if (!best_found && (fail_count != 16'hFFFF))
        fail_count <= fail_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_strip_placement_scheduler.sv
// Directed bench for strip_placement_scheduler with a placement model.
// Checks responses every valid cycle, latency, occupancy and reset/clear.
module tb_strip_placement_scheduler;

  localparam int N   = 13;
  localparam int CAP = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] occ_rd_id = 4'd0;
  logic [7:0] occ_rd_width;
`ifdef PLACEMENT_STATS_EN
  logic [15:0] placed_count;
  logic [15:0] fail_count;
`endif

  strip_placement_scheduler_if bus();

  strip_placement_scheduler #(
    .NUM_STRIPS (N),
    .STRIP_WIDTH(CAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear       (clear),
    .occ_rd_id   (occ_rd_id),
    .occ_rd_width(occ_rd_width)
`ifdef PLACEMENT_STATS_EN
    ,
    .placed_count(placed_count),
    .fail_count  (fail_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int model_occ [N];
  int exp_id, exp_x, exp_fail;
  int got_id, got_x, got_fail;
  int cur_w;
  bit pending = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Least-occupied fitting strip, lowest ID among equals.
  function automatic void model_place(input int w, output int id,
                                      output int x, output int f);
    int m;
    id = 0;
    x = 0;
    f = 1;
    if (w < 1 || w > CAP) return;
    m = 1000;
    for (int k = 0; k < N; k++)
      if (model_occ[k] + w <= CAP && model_occ[k] < m)
        m = model_occ[k];
    if (m == 1000) return;
    for (int k = N - 1; k >= 0; k--)
      if (model_occ[k] == m && model_occ[k] + w <= CAP)
        id = k;
    x = m;
    f = 0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (!pending) begin
        chk("unexpected_resp_valid", 1, 0);
      end else begin
        chk("resp_strip_id", int'(bus.resp_strip_id), exp_id);
        chk("resp_x", int'(bus.resp_x), exp_x);
        chk("resp_fail", int'(bus.resp_fail), exp_fail);
        chk("req_ready_busy", int'(bus.req_ready), 0);
      end
    end
  end

  task automatic start_req(input int w);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_width = w[7:0];
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    acc_cyc = cyc;
    cur_w = w;
    model_place(w, exp_id, exp_x, exp_fail);
    pending = 1;
  endtask

  task automatic finish_req(input int hold);
    int lat;
    int exp_lat;
    while (!bus.resp_valid && (cyc - acc_cyc) < 40) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - acc_cyc;
    exp_lat = (cur_w < 1 || cur_w > CAP) ? 2 : N + 2;
    chk("resp_latency", lat, exp_lat);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    got_id = int'(bus.resp_strip_id);
    got_x = int'(bus.resp_x);
    got_fail = int'(bus.resp_fail);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    pending = 0;
    chk("resp_valid_drop", int'(bus.resp_valid), 0);
    chk("req_ready_idle", int'(bus.req_ready), 1);
    if (exp_fail == 0) model_occ[exp_id] += cur_w;
  endtask

  task automatic do_req(input int w, input int hold);
    start_req(w);
    finish_req(hold);
  endtask

  task automatic check_occ_all();
    for (int k = 0; k < 16; k++) begin
      occ_rd_id = 4'(k);
      #1;
      chk($sformatf("occ_rd[%0d]", k), int'(occ_rd_width),
          (k < N) ? model_occ[k] : 0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pending = 0;
    for (int k = 0; k < N; k++) model_occ[k] = 0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_width = 8'd0;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < N; k++) model_occ[k] = 0;
    #2;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_strip_id", int'(bus.resp_strip_id), 0);
    chk("rst_x", int'(bus.resp_x), 0);
    chk("rst_fail", int'(bus.resp_fail), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fresh placements
    do_req(40, 0);
    chk("t1_id", got_id, 0);
    chk("t1_x", got_x, 0);
    do_req(40, 0);
    chk("t2_id", got_id, 1);
    chk("t2_x", got_x, 0);
    occ_rd_id = 4'd0;
    #1;
    chk("t2_occ0", int'(occ_rd_width), 40);

    // best fit
    apply_reset();
    do_req(100, 0);
    do_req(90, 0);
    for (int k = 0; k < 11; k++) do_req(100, 0);
    do_req(28, 0);
    chk("bf_id", got_id, 1);
    chk("bf_x", got_x, 90);
    do_req(39, 0);
    chk("bf_fail", got_fail, 1);
    check_occ_all();

    // fill
    apply_reset();
    for (int k = 0; k < N; k++) begin
      do_req(128, 0);
      chk($sformatf("fill_id%0d", k), got_id, k);
      chk($sformatf("fill_x%0d", k), got_x, 0);
    end
    do_req(1, 0);
    chk("full_fail", got_fail, 1);
    chk("full_id", got_id, 0);
    chk("full_x", got_x, 0);
    check_occ_all();

    // illegal widths
    apply_reset();
    do_req(0, 0);
    chk("w0_fail", got_fail, 1);
    do_req(129, 0);
    chk("w129_fail", got_fail, 1);
    check_occ_all();

    // backpressure
    do_req(7, 5);
    chk("bp_id", got_id, 0);
    chk("bp_x", got_x, 0);
    check_occ_all();

    // reset mid-scan
    do_req(10, 0);
    start_req(20);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    pending = 0;
    for (int k = 0; k < N; k++) model_occ[k] = 0;
    #1;
    chk("ar_req_ready", int'(bus.req_ready), 1);
    chk("ar_resp_valid", int'(bus.resp_valid), 0);
    chk("ar_strip_id", int'(bus.resp_strip_id), 0);
    chk("ar_x", int'(bus.resp_x), 0);
    chk("ar_fail", int'(bus.resp_fail), 0);
    check_occ_all();
    @(negedge clk);
    rst_n = 1'b1;

    // clear in idle
    do_req(50, 0);
    do_req(60, 0);
    @(negedge clk);
    clear = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_width = 8'd5;
    #1;
    chk("clr_req_ready", int'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.req_valid = 1'b0;
    for (int k = 0; k < N; k++) model_occ[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_no_resp", int'(bus.resp_valid), 0);
    check_occ_all();

    // clear during scan is ignored
    do_req(25, 0);
    start_req(30);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk("scan_clr_ready", int'(bus.req_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    finish_req(0);
    chk("scan_clr_id", got_id, 1);
    check_occ_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
